// File: rtl/atari_dl_pkg.sv
// Shared constants for the ANTIC display-list fetch engine.
package atari_dl_pkg;

  // Low pointer bits that advance; upper bits select the 1 KB window
  localparam int unsigned PTR_WRAP_BITS = 10;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FETCH_OP = 3'd1;
  localparam logic [2:0] ST_FETCH_LO = 3'd2;
  localparam logic [2:0] ST_FETCH_HI = 3'd3;
  localparam logic [2:0] ST_EMIT     = 3'd4;
  localparam logic [2:0] ST_WAIT_VB  = 3'd5;

  // Opcode fields
  localparam logic [3:0] DL_OP_BLANK = 4'h0;
  localparam logic [3:0] DL_OP_JUMP  = 4'h1;
  localparam int unsigned DL_BIT_LMS = 6;
  localparam int unsigned DL_BIT_JVB = 6;
  localparam int unsigned DL_BIT_DLI = 7;

  // Jumps and LMS mode lines carry a two-byte operand
  function automatic logic dl_has_operands(input logic [7:0] op);
    return (op[3:0] == DL_OP_JUMP) ||
           ((op[3:0] != DL_OP_BLANK) && op[DL_BIT_LMS]);
  endfunction

  function automatic logic dl_is_jvb(input logic [7:0] op);
    return (op[3:0] == DL_OP_JUMP) && op[DL_BIT_JVB];
  endfunction

endpackage

// File: rtl/dl_counter.sv
// Display-list pointer: 16-bit register with load and a window-wrapping increment.
module dl_counter #(
  parameter int unsigned WRAP_BITS = atari_dl_pkg::PTR_WRAP_BITS
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        i_load,
  input  logic [15:0] i_load_val,
  input  logic        i_inc,
  output logic [15:0] o_ptr
);

  localparam logic [15:0] WRAP_MASK = 16'((32'd1 << WRAP_BITS) - 32'd1);

  logic [15:0] r_ptr;
  logic [15:0] w_ptr_inc;

  // Only the low bits count; the window bits are carried over untouched
  assign w_ptr_inc = (r_ptr & ~WRAP_MASK) | ((r_ptr + 16'd1) & WRAP_MASK);

  // Pointer register; load wins over increment
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_ptr <= 16'h0000;
    end else if (i_load) begin
      r_ptr <= i_load_val;
    end else if (i_inc) begin
      r_ptr <= w_ptr_inc;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/dlist_fetch.sv
// ANTIC display-list fetch engine: fetches and decodes one instruction per fetch_req.
module dlist_fetch #(
  parameter int unsigned PTR_WRAP_BITS = atari_dl_pkg::PTR_WRAP_BITS
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        start,
  input  logic        fetch_req,
  input  logic [7:0]  DLISTL_in,
  input  logic [7:0]  DLISTH_in,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [7:0]  DLISTL_out,
  output logic [7:0]  DLISTH_out,
  output logic        dl_we,
  output logic        instr_valid,
  output logic [7:0]  instr,
  output logic [15:0] lms_addr,
  output logic        lms_valid,
  output logic        busy,
  output logic        jvb_wait
);

  import atari_dl_pkg::*;

  logic [2:0]  r_state;
  logic [2:0]  w_state_nx;
  logic        w_ptr_load;
  logic [15:0] w_ptr_load_val;
  logic        w_ptr_inc;
  logic        w_lms_done;
  logic [7:0]  w_op_cur;
  logic [15:0] w_ptr;

  logic [7:0]  r_op;
  logic [7:0]  r_lo;
  logic        r_ptr_chg;
  logic        r_dl_we;
  logic        r_mem_req;
  logic        r_instr_valid;
  logic [7:0]  r_instr;
  logic [15:0] r_lms_addr;
  logic        r_lms_valid;
  logic        r_busy;
  logic        r_jvb_wait;

  dl_counter #(
    .WRAP_BITS (PTR_WRAP_BITS)
  ) u_ptr (
    .clk        (clk),
    .rst_b      (rst_b),
    .i_load     (w_ptr_load),
    .i_load_val (w_ptr_load_val),
    .i_inc      (w_ptr_inc),
    .o_ptr      (w_ptr)
  );

  // Opcode byte is on the bus in FETCH_OP, latched afterwards
  assign w_op_cur = (r_state == ST_FETCH_OP) ? mem_data : r_op;

  // State register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state and pointer control; start overrides every state
  always_comb begin
    w_state_nx     = r_state;
    w_ptr_load     = 1'b0;
    w_ptr_load_val = {DLISTH_in, DLISTL_in};
    w_ptr_inc      = 1'b0;
    w_lms_done     = 1'b0;
    if (start) begin
      w_state_nx = ST_IDLE;
      w_ptr_load = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (fetch_req) w_state_nx = ST_FETCH_OP;
        end
        ST_FETCH_OP: begin
          if (mem_ack) begin
            w_ptr_inc  = 1'b1;
            w_state_nx = dl_has_operands(mem_data) ? ST_FETCH_LO : ST_EMIT;
          end
        end
        ST_FETCH_LO: begin
          if (mem_ack) begin
            w_ptr_inc  = 1'b1;
            w_state_nx = ST_FETCH_HI;
          end
        end
        ST_FETCH_HI: begin
          if (mem_ack) begin
            w_state_nx = ST_EMIT;
            if (r_op[3:0] == DL_OP_JUMP) begin
              w_ptr_load     = 1'b1;
              w_ptr_load_val = {mem_data, r_lo};
            end else begin
              w_ptr_inc  = 1'b1;
              w_lms_done = 1'b1;
            end
          end
        end
        ST_EMIT: begin
          w_state_nx = dl_is_jvb(r_op) ? ST_WAIT_VB : ST_IDLE;
        end
        ST_WAIT_VB: begin
          w_state_nx = ST_WAIT_VB;
        end
        default: begin
          w_state_nx = ST_IDLE;
        end
      endcase
    end
  end

  // Opcode and operand-low latches
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_op <= 8'h00;
      r_lo <= 8'h00;
    end else if (!start && mem_ack) begin
      if (r_state == ST_FETCH_OP) r_op <= mem_data;
      if (r_state == ST_FETCH_LO) r_lo <= mem_data;
    end
  end

  // Registered outputs derived from the upcoming state
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_ptr_chg     <= 1'b0;
      r_dl_we       <= 1'b0;
      r_mem_req     <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= 8'h00;
      r_lms_addr    <= 16'h0000;
      r_lms_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_jvb_wait    <= 1'b0;
    end else begin
      r_ptr_chg     <= w_ptr_load | w_ptr_inc;
      r_dl_we       <= r_ptr_chg;
      r_mem_req     <= (w_state_nx == ST_FETCH_OP) || (w_state_nx == ST_FETCH_LO) ||
                       (w_state_nx == ST_FETCH_HI);
      r_instr_valid <= (w_state_nx == ST_EMIT);
      r_lms_valid   <= w_lms_done;
      r_busy        <= (w_state_nx != ST_IDLE);
      r_jvb_wait    <= (w_state_nx == ST_WAIT_VB);
      if (w_state_nx == ST_EMIT) r_instr <= w_op_cur;
      if (w_lms_done) r_lms_addr <= {mem_data, r_lo};
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_addr    = w_ptr;
  assign DLISTL_out  = w_ptr[7:0];
  assign DLISTH_out  = w_ptr[15:8];
  assign dl_we       = r_dl_we;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign lms_addr    = r_lms_addr;
  assign lms_valid   = r_lms_valid;
  assign busy        = r_busy;
  assign jvb_wait    = r_jvb_wait;

endmodule

// File: tb/tb_dlist_fetch.sv
// Self-checking bench for dlist_fetch against a transaction-level display-list model.
module tb_dlist_fetch;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        start;
  logic        fetch_req;
  logic [7:0]  DLISTL_in;
  logic [7:0]  DLISTH_in;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic [7:0]  DLISTL_out;
  logic [7:0]  DLISTH_out;
  logic        dl_we;
  logic        instr_valid;
  logic [7:0]  instr;
  logic [15:0] lms_addr;
  logic        lms_valid;
  logic        busy;
  logic        jvb_wait;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] m_ptr;
  logic [15:0] m_lms;
  logic        m_jvb;

  dlist_fetch dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .start       (start),
    .fetch_req   (fetch_req),
    .DLISTL_in   (DLISTL_in),
    .DLISTH_in   (DLISTH_in),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .DLISTL_out  (DLISTL_out),
    .DLISTH_out  (DLISTH_out),
    .dl_we       (dl_we),
    .instr_valid (instr_valid),
    .instr       (instr),
    .lms_addr    (lms_addr),
    .lms_valid   (lms_valid),
    .busy        (busy),
    .jvb_wait    (jvb_wait)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ptr_next(input logic [15:0] p);
    return (p & 16'hFC00) | ((p + 16'd1) & 16'h03FF);
  endfunction

  function automatic int pick_wait(input int wcfg);
    return (wcfg < 0) ? int'($urandom_range(2, 0)) : wcfg;
  endfunction

  // Reload the pointer from DLIST and check the reload and its write strobe
  task automatic do_start(input logic [15:0] a);
    {DLISTH_in, DLISTL_in} = a;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_ptr", {DLISTH_out, DLISTL_out}, a);
    check("start_idle", {busy, jvb_wait, mem_req}, 0);
    tick();
    check("start_dl_we", dl_we, 1);
    m_ptr = a;
    m_jvb = 1'b0;
  endtask

  // One fetch_req transaction; wcfg<0 gives random wait states per byte
  task automatic do_instr(input int wcfg);
    logic [15:0] a [3];
    logic [15:0] p;
    logic [7:0]  op, lo, hi;
    logic        is_jump, is_lms, got;
    int nb, bi, wleft, waits, cyc, n_iv, n_we, lat;

    p = m_ptr;
    op = mem[p];
    a[0] = p;
    p = ptr_next(p);
    nb = 1;
    lo = 8'h00;
    hi = 8'h00;
    is_jump = (op[3:0] == 4'h1);
    is_lms  = (op[3:0] >= 4'h2) && op[6];
    if (is_jump || is_lms) begin
      a[1] = p; lo = mem[p]; p = ptr_next(p);
      a[2] = p; hi = mem[p]; p = ptr_next(p);
      nb = 3;
    end
    if (is_jump) p = {hi, lo};
    if (is_lms) m_lms = {hi, lo};

    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    cyc = 1; bi = 0; waits = 0; n_iv = 0; n_we = 0; got = 1'b0; lat = 0;
    wleft = pick_wait(wcfg);
    while (!got && cyc < 100) begin
      fetch_req = busy ? ($urandom_range(3, 0) == 0) : 1'b0;
      if (mem_req) begin
        if (bi < nb) check("mem_addr", mem_addr, a[bi]);
        else check("extra_req", 1, 0);
        if (wleft == 0) begin
          mem_ack = 1'b1;
          mem_data = mem[mem_addr];
          bi++;
          wleft = pick_wait(wcfg);
        end else begin
          wleft--;
          waits++;
        end
      end
      if (dl_we) n_we++;
      if (instr_valid) begin
        got = 1'b1;
        n_iv++;
        lat = cyc;
        check("instr", instr, op);
        check("lms_valid", lms_valid, is_lms);
        check("lms_addr", lms_addr, m_lms);
      end
      tick();
      mem_ack = 1'b0;
      fetch_req = 1'b0;
      cyc++;
    end
    check("got_instr", got, 1);
    check("latency", lat, 1 + nb + waits);
    for (int k = 0; k < 2; k++) begin
      if (dl_we) n_we++;
      if (instr_valid) n_iv++;
      tick();
    end
    check("n_instr_valid", n_iv, 1);
    check("n_dl_we", n_we, nb);
    check("ptr", {DLISTH_out, DLISTL_out}, p);
    check("jvb_wait", jvb_wait, is_jump && op[6]);
    check("busy_after", busy, is_jump && op[6]);
    check("req_after", mem_req, 0);
    m_ptr = p;
    m_jvb = is_jump && op[6];
  endtask

  initial begin
    rst_b = 1'b0; start = 1'b0; fetch_req = 1'b0;
    DLISTL_in = 8'h00; DLISTH_in = 8'h00;
    mem_ack = 1'b0; mem_data = 8'h00;
    m_ptr = 16'h0000; m_lms = 16'h0000; m_jvb = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

    tick(); tick();
    check("rst_ptr", {DLISTH_out, DLISTL_out}, 16'h0000);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_ctl", {mem_req, dl_we, instr_valid, lms_valid, busy, jvb_wait}, 0);
    check("rst_data", {instr, lms_addr}, 0);
    rst_b = 1'b1;
    tick();

    // Plain mode line
    mem[16'h2000] = 8'h02;
    do_start(16'h2000);
    do_instr(0);

    // LMS with two wait states per byte
    mem[16'h2000] = 8'h42; mem[16'h2001] = 8'h00; mem[16'h2002] = 8'h40;
    do_start(16'h2000);
    do_instr(2);
    check("lms_final", lms_addr, 16'h4000);

    // Pointer wraps inside the 1 KB window
    mem[16'h23FF] = 8'h0F;
    do_start(16'h23FF);
    do_instr(0);
    check("wrap_ptr", {DLISTH_out, DLISTL_out}, 16'h2000);

    // Jump-and-wait-for-vblank, then fetch_req ignored, then restart
    mem[16'h2100] = 8'h41; mem[16'h2101] = 8'h00; mem[16'h2102] = 8'h30;
    do_start(16'h2100);
    do_instr(1);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    check("jvb_ignore_req", mem_req, 0);
    check("jvb_hold", jvb_wait, 1);
    do_start(16'h3000);
    check("jvb_exit", {jvb_wait, busy}, 0);

    // Abort during FETCH_LO
    mem[16'h2400] = 8'h42; mem[16'h2401] = 8'h11; mem[16'h2402] = 8'h22;
    do_start(16'h2400);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    mem_ack = 1'b1; mem_data = mem[mem_addr];
    tick();
    mem_ack = 1'b0;
    check("abort_in_lo", {mem_req, mem_addr}, {1'b1, 16'h2401});
    {DLISTH_in, DLISTL_in} = 16'h5123;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("abort_req_drop", mem_req, 0);
    check("abort_ptr", {DLISTH_out, DLISTL_out}, 16'h5123);
    begin
      int n_iv_ab;
      n_iv_ab = 0;
      for (int k = 0; k < 4; k++) begin
        if (instr_valid) n_iv_ab++;
        tick();
      end
      check("abort_no_instr", n_iv_ab, 0);
    end
    m_ptr = 16'h5123;
    do_instr(-1);

    // Reset during FETCH_HI
    mem[16'h2600] = 8'h42; mem[16'h2601] = 8'h00; mem[16'h2602] = 8'h40;
    do_start(16'h2600);
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_ack = 1'b1; mem_data = mem[mem_addr];
      tick();
      mem_ack = 1'b0;
    end
    check("pre_rst_hi", {mem_req, mem_addr}, {1'b1, 16'h2602});
    rst_b = 1'b0;
    #1;
    check("mid_rst_ptr", {DLISTH_out, DLISTL_out, mem_addr}, 0);
    check("mid_rst_ctl", {mem_req, dl_we, instr_valid, lms_valid, busy, jvb_wait}, 0);
    check("mid_rst_data", {instr, lms_addr}, 0);
    tick();
    rst_b = 1'b1;
    tick();
    m_ptr = 16'h0000; m_lms = 16'h0000; m_jvb = 1'b0;
    mem[16'h0000] = 8'h03;
    do_instr(0);

    // Random display lists with random wait states
    for (int t = 0; t < 60; t++) begin
      if (m_jvb || (t % 15 == 0)) do_start(16'($urandom));
      do_instr(-1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dlist_fetch.md
# dlist_fetch

Display-list fetch engine for the ANTIC side of the memory map. It takes the display-list pointer held in the DLISTH/DLISTL registers, fetches display-list instructions and their operand bytes over a request/acknowledge memory port, and decodes blank, jump and mode-line instructions. It writes the advanced pointer back through the ANTIC register write path, and hands each decoded instruction to the line-timing logic.

## Interface
Parameters:
- `PTR_WRAP_BITS`, default 10: low pointer bits that increment; the upper bits stay fixed (ANTIC 1 KB display-list window).

Ports:
- `clk` in 1: system clock (phi2 domain).
- `rst_b` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse at the end of vertical blank; reloads the pointer from `DLISTH_in:DLISTL_in`.
- `fetch_req` in 1: one-cycle pulse from line timing requesting the next instruction.
- `DLISTL_in`, `DLISTH_in` in 8 each: current DLISTL/DLISTH register values.
- `mem_req` out 1: memory read request.
- `mem_addr` out 16: read address, valid while `mem_req` is high.
- `mem_ack` in 1: read accepted; `mem_data` is valid in the same cycle.
- `mem_data` in 8: read data.
- `DLISTL_out`, `DLISTH_out` out 8 each: live pointer value.
- `dl_we` out 1: one-cycle pulse telling the memory map to latch `DLISTL_out`/`DLISTH_out`.
- `instr_valid` out 1: one-cycle pulse; `instr`, `lms_addr` and `lms_valid` are valid in this cycle.
- `instr` out 8: instruction byte as fetched.
- `lms_addr` out 16: memory-scan address from an LMS instruction.
- `lms_valid` out 1: `lms_addr` is new in this instruction.
- `busy` out 1: high in every state except IDLE.
- `jvb_wait` out 1: high while in WAIT_VB.

## Operation
- Instruction decode uses `instr[3:0]`:
  - 0: blank lines, count = `instr[6:4]`+1; no operands.
  - 1: jump; fetch lo and hi bytes, then load the full 16-bit pointer. If `instr[6]` is set (JVB), enter WAIT_VB after emitting.
  - 2–F: mode line; if `instr[6]` is set (LMS), fetch lo and hi bytes into `lms_addr`.
- `instr[7]` (DLI) passes through unmodified.
- Pointer increment: after each acknowledged byte, the low `PTR_WRAP_BITS` bits increment modulo 2^10 and bits 15:10 are unchanged. Example: 0x23FF increments to 0x2000.
- Jump: the pointer loads lo/hi as-is, with no wrap masking.
- `dl_we` pulses in the cycle after any pointer change (increment, jump load or `start` reload).
- States:
  - IDLE: `fetch_req` moves to FETCH_OP.
  - FETCH_OP: on ack, go to FETCH_LO if operands are needed, else EMIT.
  - FETCH_LO: on ack, go to FETCH_HI.
  - FETCH_HI: on ack, go to EMIT.
  - EMIT: one cycle, then IDLE, or WAIT_VB for JVB.
  - WAIT_VB: exits only on `start`.
- `mem_req` is high throughout FETCH_*. `mem_addr` equals the pointer and updates in the cycle after each ack.
- `start` has priority over everything, in any state:
  - the pointer reloads;
  - the state returns to IDLE and `mem_req` drops the next cycle;
  - any partially fetched instruction is discarded, with no `instr_valid`.
- `fetch_req` while `busy` is ignored and not queued.
- `start` and `fetch_req` in the same IDLE cycle: the reload happens and `fetch_req` is dropped.
- `lms_valid` is 0 on instructions without LMS. `lms_addr` holds its last value.

## Timing
- Reset values: state IDLE, pointer 0x0000, and all outputs 0 (`mem_req`, `mem_addr`, `DLISTL_out`, `DLISTH_out`, `dl_we`, `instr_valid`, `instr`, `lms_addr`, `lms_valid`, `busy`, `jvb_wait`).
- `fetch_req` at cycle 0 gives `mem_req` high at cycle 1. `mem_ack` may arrive in the first request cycle.
- Zero-wait latencies:
  - plain instruction: ack at cycle 1, `instr_valid` at cycle 2;
  - LMS or jump: acks at cycles 1, 2 and 3, `instr_valid` at cycle 4.
- Each wait cycle (req high, ack low) adds one cycle and holds `mem_addr` stable.
- `start` at cycle n gives the reloaded pointer visible at n+1 and `dl_we` at n+2.
- Asserting `rst_b` low mid-fetch clears all state immediately. No transaction resumes.

## Structure
- Package `atari_dl_pkg` holds:
  - state encoding;
  - opcode field constants: `DL_OP_BLANK`=0, `DL_OP_JUMP`=1, LMS bit 6, JVB bit 6, DLI bit 7;
  - `PTR_WRAP_BITS`.
- Sub-module `dl_counter`: 16-bit pointer with synchronous load and a 10-bit wrapping increment. It is separately testable.
- Everything else (FSM, operand latches, decode) lives in `dlist_fetch`.

## Test plan
- Mode line, no LMS: start with DLIST = 0x2000, memory[0x2000] = 0x02, `fetch_req` → `instr_valid` at cycle 2 with `instr` = 0x02, `lms_valid` = 0, pointer 0x2001, one `dl_we`.
- LMS with wait states: memory 0x2000..2 = 0x42,0x00,0x40, 2 wait cycles per byte → `lms_addr` = 0x4000, `lms_valid` = 1, pointer 0x2003, `mem_addr` stable during each wait.
- Wrap-around: pointer 0x23FF holding opcode 0x0F → pointer 0x2000 after the fetch, not 0x2400.
- JVB: memory = 0x41,0x00,0x30 → pointer 0x3000, `jvb_wait` = 1, later `fetch_req` ignored; `start` with DLIST = 0x3000 → IDLE, `jvb_wait` = 0.
- Abort: `start` asserted during FETCH_LO → no `instr_valid`, `mem_req` low the next cycle, pointer equals the new DLIST.
- Reset mid-fetch: `rst_b` low during FETCH_HI → all outputs 0 in the same cycle; next `fetch_req` starts from 0x0000.
